// File: rtl/word_capture.sv
`default_nettype none
// ============================================================================
//  Module   : word_capture
//  Brief    : Counts shift strobes against an upstream DEPTH-bit shift
//             register and snapshots its parallel output once per full word.
//             The captured word is held in a one-entry output buffer with a
//             valid/ready handshake. Sticky flags report dropped words and
//             frames that end on a partial word.
//  Revision : 1.0 - initial release
// ============================================================================
module word_capture #(
  parameter int DEPTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             shift_en,
  input  logic [DEPTH-1:0] p_in,
  input  logic             rd_ready,
  input  logic             err_clr,
  output logic [DEPTH-1:0] word_out,
  output logic             word_valid,
  output logic [5:0]       bit_cnt,
  output logic             overrun,
  output logic             short_frame
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [5:0] c_last_cnt = 6'(DEPTH - 1);
  localparam logic [5:0] c_full_cnt = 6'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [5:0]       w_cnt_nxt;
  logic [DEPTH-1:0] r_word;
  logic [DEPTH-1:0] w_word_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;
  logic             r_short;
  logic             w_short_nxt;
  logic             w_set_overrun;
  logic             w_set_short;

  // Next-state, shift counting, output buffer handshake and sticky flags.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_word_nxt    = r_word;
    w_valid_nxt   = r_valid;
    w_set_overrun = 1'b0;
    w_set_short   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 6'd0;
        if (frame) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A falling frame wins over a coincident shift strobe.
        if (!frame) begin
          w_set_short = (r_cnt != 6'd0);
          w_cnt_nxt   = 6'd0;
          w_state_nxt = ST_IDLE;
        end else if (shift_en) begin
          if (r_cnt == c_last_cnt) begin
            w_cnt_nxt   = c_full_cnt;
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      ST_CAPTURE: begin
        // A strobe in this cycle is the first bit of the next word, but only
        // while the frame continues; leaving for IDLE keeps the count at 0.
        w_cnt_nxt   = (frame && shift_en) ? 6'd1 : 6'd0;
        w_state_nxt = frame ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = 6'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // p_in is only valid one cycle after the last shift, i.e. in CAPTURE.
    if (r_state == ST_CAPTURE) begin
      if (!r_valid || rd_ready) begin
        w_word_nxt  = p_in;
        w_valid_nxt = 1'b1;
      end else begin
        w_set_overrun = 1'b1;
      end
    end else if (r_valid && rd_ready) begin
      w_valid_nxt = 1'b0;
    end

    // A new error event takes priority over a clear in the same cycle.
    w_overrun_nxt = w_set_overrun | (r_overrun & ~err_clr);
    w_short_nxt   = w_set_short | (r_short & ~err_clr);
  end

  // State register and all output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 6'd0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_word    <= w_word_nxt;
      r_valid   <= w_valid_nxt;
      r_overrun <= w_overrun_nxt;
      r_short   <= w_short_nxt;
    end
  end

  assign word_out    = r_word;
  assign word_valid  = r_valid;
  assign bit_cnt     = r_cnt;
  assign overrun     = r_overrun;
  assign short_frame = r_short;

endmodule
`default_nettype wire

// File: tb/tb_word_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_capture
//  Brief    : Self-checking bench for word_capture. Directed scenarios followed
//             by randomized traffic; a reference model predicts every output
//             and queues each word it expects the consumer to receive.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_word_capture;

  localparam int DEPTH = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame = 1'b0;
  logic             shift_en = 1'b0;
  logic [DEPTH-1:0] p_in = '0;
  logic             rd_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic [DEPTH-1:0] word_out;
  logic             word_valid;
  logic [5:0]       bit_cnt;
  logic             overrun;
  logic             short_frame;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: shifts seen in the current word, whether a full word is
  // waiting to be snapshotted, whether a frame is open, the buffered word.
  int               m_cnt = 0;
  bit               m_pending = 0;
  bit               m_in_frame = 0;
  bit               m_valid = 0;
  bit               m_ov = 0;
  bit               m_sf = 0;
  bit               m_init = 0;
  bit               s_ov, s_sf;
  logic [DEPTH-1:0] m_word = '0;
  logic [DEPTH-1:0] exp_q[$];

  int valid_rises = 0;
  bit prev_valid = 0;

  word_capture #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame       (frame),
    .shift_en    (shift_en),
    .p_in        (p_in),
    .rd_ready    (rd_ready),
    .err_clr     (err_clr),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .bit_cnt     (bit_cnt),
    .overrun     (overrun),
    .short_frame (short_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, evaluated on the same edge the DUT uses.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_pending = 0; m_in_frame = 0; m_valid = 0;
      m_ov = 0; m_sf = 0; m_word = '0; exp_q.delete(); m_init = 1;
    end else if (m_init) begin
      s_ov = 0; s_sf = 0;
      if (m_pending) begin
        m_pending = 0;
        if (!m_valid || rd_ready) begin
          m_word = p_in; m_valid = 1; exp_q.push_back(p_in);
        end else begin
          s_ov = 1;
        end
        m_cnt = (frame && shift_en) ? 1 : 0;
        m_in_frame = frame;
      end else begin
        if (m_valid && rd_ready) m_valid = 0;
        if (!m_in_frame) begin
          m_in_frame = frame;
        end else if (!frame) begin
          s_sf = (m_cnt > 0); m_cnt = 0; m_in_frame = 0;
        end else if (shift_en) begin
          m_cnt++;
          if (m_cnt == DEPTH) m_pending = 1;
        end
      end
      m_ov = s_ov || (m_ov && !err_clr);
      m_sf = s_sf || (m_sf && !err_clr);
    end
  end

  // Monitor: mid-cycle compare of outputs, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (m_init) begin
      chk("word_valid", word_valid, m_valid);
      chk("bit_cnt", bit_cnt, m_cnt);
      chk("overrun", overrun, m_ov);
      chk("short_frame", short_frame, m_sf);
      chk("word_out", word_out, m_word);
      if (word_valid === 1'b1 && !prev_valid) valid_rises++;
      prev_valid = (word_valid === 1'b1);
      if (word_valid === 1'b1 && rd_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_empty: got word %0h expected no word", word_out);
        end else begin
          chk("sb_word", word_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic shifts(input int n);
    frame = 1'b1;
    shift_en = 1'b1;
    repeat (n) step();
    shift_en = 1'b0;
  endtask

  initial begin : driver
    int r0;
    repeat (2) step();
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_sf", short_frame, 0);
    rst = 1'b0;

    // Single clean word.
    p_in = 24'hA5C3F0; frame = 1'b1; step();
    shifts(24);
    chk("s1_cnt_full", bit_cnt, 24);
    step();
    chk("s1_word", word_out, 24'hA5C3F0);
    chk("s1_valid", word_valid, 1);
    chk("s1_cnt", bit_cnt, 0);

    // Second word while the first is unread: dropped, overrun set.
    p_in = 24'h123456;
    shifts(24);
    step();
    chk("s2_ov", overrun, 1);
    chk("s2_word_held", word_out, 24'hA5C3F0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("s2_ov_clr", overrun, 0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("s2_consumed", word_valid, 0);

    // Short frame, with a shift strobe coincident with frame falling.
    shifts(10);
    chk("s3_cnt10", bit_cnt, 10);
    frame = 1'b0; shift_en = 1'b1; step();
    chk("s3_sf", short_frame, 1);
    chk("s3_cnt", bit_cnt, 0);
    chk("s3_valid", word_valid, 0);
    step();
    chk("s3_idle_cnt", bit_cnt, 0);
    shift_en = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("s3_sf_clr", short_frame, 0);

    // Two-word frame, 48 contiguous strobes, consumer always ready.
    frame = 1'b1; step();
    rd_ready = 1'b1; r0 = valid_rises; p_in = 24'h00BEEF;
    shifts(25);
    chk("s4_cnt_after_cap", bit_cnt, 1);
    p_in = 24'h777000;
    shifts(23);
    chk("s4_cnt_full", bit_cnt, 24);
    step();
    chk("s4_word2", word_out, 24'h777000);
    step();
    chk("s4_rises", valid_rises - r0, 2);
    rd_ready = 1'b0;

    // Reset mid-frame, then a clean word with frame held high.
    frame = 1'b0; step();
    frame = 1'b1; step();
    shifts(12);
    rst = 1'b1; step();
    chk("s5_cnt", bit_cnt, 0);
    chk("s5_valid", word_valid, 0);
    chk("s5_word", word_out, 0);
    chk("s5_sf", short_frame, 0);
    chk("s5_ov", overrun, 0);
    rst = 1'b0; step();
    p_in = 24'h5A5A5A;
    shifts(24);
    step();
    chk("s5_cap_valid", word_valid, 1);
    chk("s5_cap_word", word_out, 24'h5A5A5A);
    chk("s5_cap_sf", short_frame, 0);

    // Capture coincident with the consumer reading the previous word.
    p_in = 24'h0F0F0F;
    shifts(24);
    p_in = 24'hC0FFEE; rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("s6_word", word_out, 24'hC0FFEE);
    chk("s6_valid", word_valid, 1);
    chk("s6_ov", overrun, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      frame    = ($urandom_range(0, 19) != 0);
      shift_en = ($urandom_range(0, 9) < 7);
      rd_ready = ($urandom_range(0, 2) != 0);
      err_clr  = ($urandom_range(0, 29) == 0);
      p_in     = 24'($urandom());
      step();
    end
    rst = 1'b0; frame = 1'b0; shift_en = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/word_capture.md
WORD_CAPTURE -- requirements
Module: word_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 24: word width in bits, equal to the depth of the upstream shift register; legal range 2..63.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port frame, input, 1 bit: high while a serial transfer is in progress.
REQ-005 The block SHALL have port shift_en, input, 1 bit: the same strobe that drives the upstream shift register enable.
REQ-006 The block SHALL have port p_in, input, DEPTH bits: the parallel output of the upstream shift register.
REQ-007 The block SHALL have port rd_ready, input, 1 bit: the consumer accepts word_out this cycle.
REQ-008 The block SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-009 The block SHALL have port word_out, output, DEPTH bits: the captured word.
REQ-010 The block SHALL have port word_valid, output, 1 bit: word_out holds an unread word.
REQ-011 The block SHALL have port bit_cnt, output, 6 bits: the number of shifts counted in the current word.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, a captured word was dropped.
REQ-013 The block SHALL have port short_frame, output, 1 bit: sticky flag, frame ended with a partial word.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, SHIFT and CAPTURE; reset state IDLE.
REQ-015 IDLE SHALL transition to SHIFT when frame=1; shift_en is ignored in IDLE and bit_cnt stays 0.
REQ-016 In SHIFT, each cycle with shift_en=1 SHALL increment bit_cnt by 1.
REQ-017 In SHIFT, shift_en=1 with bit_cnt=DEPTH-1 SHALL set bit_cnt to DEPTH and move to CAPTURE (upstream p_in becomes valid one cycle later).
REQ-018 In CAPTURE, the block SHALL sample p_in and reset bit_cnt to 0 (or to 1 if shift_en=1 that cycle); next state is SHIFT if frame=1, else IDLE.
REQ-019 Capture with word_valid=0, or with word_valid=1 and rd_ready=1 in the same cycle, SHALL load word_out and set word_valid=1.
REQ-020 Capture with word_valid=1 and rd_ready=0 SHALL keep the old word_out unchanged, drop the new word and set overrun=1.
REQ-021 word_valid=1 and rd_ready=1 with no capture SHALL clear word_valid on the next edge; word_out SHALL hold its last value.
REQ-022 rd_ready while word_valid=0 SHALL have no effect.
REQ-023 frame=0 in SHIFT with bit_cnt>0 SHALL set short_frame=1, clear bit_cnt to 0 and move to IDLE.
REQ-024 frame=0 in SHIFT with bit_cnt=0 SHALL move to IDLE with no error.
REQ-025 A shift_en coincident with frame falling in SHIFT SHALL be ignored.
REQ-026 Frames longer than DEPTH SHALL capture one word per DEPTH shifts (multi-word frames).
REQ-027 err_clr=1 SHALL clear overrun and short_frame; a new error event in the same cycle SHALL take priority and leave its flag set.
REQ-028 bit_cnt SHALL be zero-extended to 6 bits.

Reset
REQ-029 With rst=1 at a clk edge, the block SHALL enter IDLE and set word_out=0, word_valid=0, bit_cnt=0, overrun=0 and short_frame=0.
REQ-030 Reset SHALL override all other inputs.
REQ-031 Reset mid-frame SHALL discard the partial word and SHALL NOT set short_frame.
REQ-032 After reset deassertion with frame held high, the FSM SHALL enter SHIFT on the next edge.

Verification
REQ-033 Bench scenario: DEPTH=24; frame=1, 24 shift_en pulses, p_in=24'hA5C3F0 in the CAPTURE cycle -> word_out=24'hA5C3F0 and word_valid=1 on the next edge; bit_cnt=0.
REQ-034 Bench scenario: word_valid=1, rd_ready=0, second 24-shift word completes -> overrun=1 and word_out holds the first word; err_clr pulse -> overrun=0.
REQ-035 Bench scenario: frame=1, 10 shift_en pulses, frame=0 -> short_frame=1, bit_cnt=0, state IDLE, word_valid unchanged.
REQ-036 Bench scenario: 48 contiguous shift_en pulses in one frame with rd_ready=1 -> two captures and word_valid pulses; shift_en in the CAPTURE cycle gives bit_cnt=1.
REQ-037 Bench scenario: rst=1 asserted after 12 shifts -> all outputs 0 next edge, short_frame=0; 24 further shifts after release -> one clean capture.
REQ-038 Bench scenario: rd_ready=1 asserted in the same cycle as a capture with word_valid=1 -> new word loaded, word_valid stays 1, overrun=0.
